// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the instruction memory.
//
// Receives a framed byte stream over a valid/ready handshake:
//   N[7:0], N[15:8], N x {instr[7:0], {7'b0, instr[8]}}, XOR checksum of the 2N instruction bytes.
// Each instruction byte pair becomes one IW-bit word. Words are written to consecutive
// addresses starting at 0. After the checksum byte the loader pulses o_done on a clean
// load, or sets the sticky o_err flag.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      synchronous active-high reset, overrides everything
//   i_start      arms a load (sampled only when idle)
//   i_in_valid   source presents a byte on i_in_data
//   i_in_data    stream byte
//   o_in_ready   loader accepts a byte this cycle (decoded from state only)
//   o_im_we      instruction-memory write strobe, one cycle per word
//   o_im_addr    write address (held after the strobe)
//   o_im_wdata   write data (held after the strobe)
//   o_busy       high in every state except idle
//   o_done       one-cycle pulse after a clean load
//   o_err        sticky error, cleared by reset or by an accepted start
module prog_loader #(
    parameter int unsigned IW = 9,
    parameter int unsigned AW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_in_valid,
    input  logic [7:0]    i_in_data,
    output logic          o_in_ready,
    output logic          o_im_we,
    output logic [AW-1:0] o_im_addr,
    output logic [IW-1:0] o_im_wdata,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    // Count is compared in 17 bits so DEPTH itself is representable for AW up to 16.
    localparam logic [16:0] DEPTH = 17'(2 ** AW);

    typedef enum logic [2:0] {
        StIdle,
        StCntLo,
        StCntHi,
        StInsLo,
        StInsHi,
        StChk,
        StDone
    } state_e;

    state_e        r_state, w_state_next;
    logic [15:0]   r_n, w_n_next;
    logic [AW:0]   r_cnt, w_cnt_next;
    logic [7:0]    r_acc, w_acc_next;
    logic [7:0]    r_low, w_low_next;
    logic          r_im_we, w_im_we_next;
    logic [AW-1:0] r_im_addr, w_im_addr_next;
    logic [IW-1:0] r_im_wdata, w_im_wdata_next;
    logic          r_err, w_err_next;

    logic          w_xfer;
    logic [15:0]   w_n_full;
    logic          w_last_word;

    assign o_in_ready = (r_state == StCntLo) || (r_state == StCntHi) ||
                        (r_state == StInsLo) || (r_state == StInsHi) ||
                        (r_state == StChk);
    assign w_xfer     = i_in_valid && o_in_ready;

    // Full count as it becomes known during the high-byte transfer.
    assign w_n_full    = {i_in_data, r_n[7:0]};
    // The word being written now is word N when counter+1 reaches N.
    assign w_last_word = ((16'(r_cnt) + 16'd1) == r_n);

    always_comb begin
        w_state_next    = r_state;
        w_n_next        = r_n;
        w_cnt_next      = r_cnt;
        w_acc_next      = r_acc;
        w_low_next      = r_low;
        w_im_we_next    = 1'b0;
        w_im_addr_next  = r_im_addr;
        w_im_wdata_next = r_im_wdata;
        w_err_next      = r_err;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StCntLo;
                    w_err_next   = 1'b0;
                    w_cnt_next   = '0;
                    w_acc_next   = '0;
                end
            end
            StCntLo: begin
                if (w_xfer) begin
                    w_n_next     = {r_n[15:8], i_in_data};
                    w_state_next = StCntHi;
                end
            end
            StCntHi: begin
                if (w_xfer) begin
                    w_n_next = w_n_full;
                    if ({1'b0, w_n_full} > DEPTH) begin
                        w_err_next   = 1'b1;
                        w_state_next = StIdle;
                    end else if (w_n_full == 16'd0) begin
                        w_state_next = StChk;
                    end else begin
                        w_state_next = StInsLo;
                    end
                end
            end
            StInsLo: begin
                if (w_xfer) begin
                    w_low_next   = i_in_data;
                    w_acc_next   = r_acc ^ i_in_data;
                    w_state_next = StInsHi;
                end
            end
            StInsHi: begin
                if (w_xfer) begin
                    w_acc_next = r_acc ^ i_in_data;
                    if (|i_in_data[7:1]) begin
                        w_err_next   = 1'b1;
                        w_state_next = StIdle;
                    end else begin
                        w_im_we_next    = 1'b1;
                        w_im_addr_next  = r_cnt[AW-1:0];
                        w_im_wdata_next = IW'({i_in_data[0], r_low});
                        w_cnt_next      = r_cnt + 1'b1;
                        w_state_next    = w_last_word ? StChk : StInsLo;
                    end
                end
            end
            StChk: begin
                if (w_xfer) begin
                    if (i_in_data == r_acc) begin
                        w_state_next = StDone;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = StIdle;
                    end
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_n        <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_low      <= '0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_n        <= w_n_next;
            r_cnt      <= w_cnt_next;
            r_acc      <= w_acc_next;
            r_low      <= w_low_next;
            r_im_we    <= w_im_we_next;
            r_im_addr  <= w_im_addr_next;
            r_im_wdata <= w_im_wdata_next;
            r_err      <= w_err_next;
        end
    end

    assign o_im_we    = r_im_we;
    assign o_im_addr  = r_im_addr;
    assign o_im_wdata = r_im_wdata;
    assign o_busy     = (r_state != StIdle);
    assign o_done     = (r_state == StDone);
    assign o_err      = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: per-cycle vector table plus directed multi-cycle sequences
// (backpressure, reset mid-load, full-depth load).
module tb_prog_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       im_we;
    logic [7:0] im_addr;
    logic [8:0] im_wdata;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    prog_loader #(
        .IW(9),
        .AW(8)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_in_valid (in_valid),
        .i_in_data  (in_data),
        .o_in_ready (in_ready),
        .o_im_we    (im_we),
        .o_im_addr  (im_addr),
        .o_im_wdata (im_wdata),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write / done monitor, sampled on the falling edge.
    logic [7:0] wr_addr[$];
    logic [8:0] wr_data[$];
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (im_we) begin
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
        end
        if (done) done_cnt++;
    end

    typedef struct {
        logic       start;
        logic       valid;
        logic [7:0] data;
        logic       ready;
        logic       we;
        logic [7:0] addr;
        logic [8:0] wdata;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vecs[31];

    function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                                input logic r, input logic w, input logic [7:0] a,
                                input logic [8:0] wd, input logic b, input logic dn,
                                input logic e);
        vec_t t;
        t.start = s; t.valid = v; t.data = d; t.ready = r; t.we = w;
        t.addr = a; t.wdata = wd; t.busy = b; t.done = dn; t.err = e;
        return t;
    endfunction

    function automatic logic [21:0] outs();
        return {in_ready, im_we, im_addr, im_wdata, busy, done, err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one byte and hold it until accepted (bounded).
    task automatic xfer(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("xfer_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic idle_gap(input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (g) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_clean(input int max_gap);
        logic [7:0] s[7];
        s[0] = 8'h02; s[1] = 8'h00; s[2] = 8'hC5; s[3] = 8'h01;
        s[4] = 8'hF3; s[5] = 8'h00; s[6] = 8'h37;
        for (int i = 0; i < 7; i++) begin
            idle_gap(max_gap);
            xfer(s[i]);
        end
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic check_clean(input string tag);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check({tag, "_w0"}, {15'd0, wr_addr[0], wr_data[0]}, {15'd0, 8'h00, 9'h1C5});
            check({tag, "_w1"}, {15'd0, wr_addr[1], wr_data[1]}, {15'd0, 8'h01, 9'h0F3});
        end
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_err_busy"}, {30'd0, err, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] ck;
        int         bad;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Clean load, reserved-bit error, stray bytes in idle, oversize count,
        // bad checksum, N == 0.
        vecs[0]  = mk(1, 0, 8'h00, 1, 0, 8'h00, 9'h000, 1, 0, 0);
        vecs[1]  = mk(0, 1, 8'h02, 1, 0, 8'h00, 9'h000, 1, 0, 0);
        vecs[2]  = mk(0, 1, 8'h00, 1, 0, 8'h00, 9'h000, 1, 0, 0);
        vecs[3]  = mk(0, 1, 8'hC5, 1, 0, 8'h00, 9'h000, 1, 0, 0);
        vecs[4]  = mk(0, 1, 8'h01, 1, 1, 8'h00, 9'h1C5, 1, 0, 0);
        vecs[5]  = mk(0, 1, 8'hF3, 1, 0, 8'h00, 9'h1C5, 1, 0, 0);
        vecs[6]  = mk(0, 1, 8'h00, 1, 1, 8'h01, 9'h0F3, 1, 0, 0);
        vecs[7]  = mk(0, 1, 8'h37, 0, 0, 8'h01, 9'h0F3, 1, 1, 0);
        vecs[8]  = mk(0, 0, 8'h00, 0, 0, 8'h01, 9'h0F3, 0, 0, 0);
        vecs[9]  = mk(1, 0, 8'h00, 1, 0, 8'h01, 9'h0F3, 1, 0, 0);
        vecs[10] = mk(0, 1, 8'h01, 1, 0, 8'h01, 9'h0F3, 1, 0, 0);
        vecs[11] = mk(0, 1, 8'h00, 1, 0, 8'h01, 9'h0F3, 1, 0, 0);
        vecs[12] = mk(0, 1, 8'hAA, 1, 0, 8'h01, 9'h0F3, 1, 0, 0);
        vecs[13] = mk(0, 1, 8'h03, 0, 0, 8'h01, 9'h0F3, 0, 0, 1);
        vecs[14] = mk(0, 1, 8'h55, 0, 0, 8'h01, 9'h0F3, 0, 0, 1);
        vecs[15] = mk(1, 0, 8'h00, 1, 0, 8'h01, 9'h0F3, 1, 0, 0);
        vecs[16] = mk(0, 1, 8'h01, 1, 0, 8'h01, 9'h0F3, 1, 0, 0);
        vecs[17] = mk(0, 1, 8'h01, 0, 0, 8'h01, 9'h0F3, 0, 0, 1);
        vecs[18] = mk(1, 0, 8'h00, 1, 0, 8'h01, 9'h0F3, 1, 0, 0);
        vecs[19] = mk(0, 1, 8'h02, 1, 0, 8'h01, 9'h0F3, 1, 0, 0);
        vecs[20] = mk(0, 1, 8'h00, 1, 0, 8'h01, 9'h0F3, 1, 0, 0);
        vecs[21] = mk(0, 1, 8'hC5, 1, 0, 8'h01, 9'h0F3, 1, 0, 0);
        vecs[22] = mk(0, 1, 8'h01, 1, 1, 8'h00, 9'h1C5, 1, 0, 0);
        vecs[23] = mk(0, 1, 8'hF3, 1, 0, 8'h00, 9'h1C5, 1, 0, 0);
        vecs[24] = mk(0, 1, 8'h00, 1, 1, 8'h01, 9'h0F3, 1, 0, 0);
        vecs[25] = mk(0, 1, 8'h36, 0, 0, 8'h01, 9'h0F3, 0, 0, 1);
        vecs[26] = mk(1, 0, 8'h00, 1, 0, 8'h01, 9'h0F3, 1, 0, 0);
        vecs[27] = mk(0, 1, 8'h00, 1, 0, 8'h01, 9'h0F3, 1, 0, 0);
        vecs[28] = mk(0, 1, 8'h00, 1, 0, 8'h01, 9'h0F3, 1, 0, 0);
        vecs[29] = mk(0, 1, 8'h00, 0, 0, 8'h01, 9'h0F3, 1, 1, 0);
        vecs[30] = mk(0, 0, 8'h00, 0, 0, 8'h01, 9'h0F3, 0, 0, 0);

        repeat (2) begin
            @(posedge clk); #1;
        end
        check("reset_outputs", 32'(outs()), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 31; i++) begin
            start    = vecs[i].start;
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'({vecs[i].ready, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                       vecs[i].busy, vecs[i].done, vecs[i].err}));
        end
        start    = 1'b0;
        in_valid = 1'b0;

        // Clean load after the error above, then with random idle gaps.
        clear_mon();
        do_start();
        send_clean(0);
        check_clean("clean");

        clear_mon();
        do_start();
        send_clean(3);
        check_clean("backpressure");

        // Reset while in INS_HI of the second word.
        clear_mon();
        do_start();
        xfer(8'h02); xfer(8'h00); xfer(8'hC5); xfer(8'h01); xfer(8'hF3);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(posedge clk); #1;
        check("midreset_outputs", 32'(outs()), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("midreset_nwrites", 32'(wr_addr.size()), 32'd1);
        clear_mon();
        do_start();
        send_clean(0);
        check_clean("after_reset");

        // N == DEPTH: 256 words, addresses 0..255 with no wrap.
        clear_mon();
        do_start();
        xfer(8'h00);
        xfer(8'h01);
        ck = 8'h00;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] lo;
            logic [7:0] hi;
            lo = 8'(i) ^ 8'h5A;
            hi = {7'd0, 1'(i)};
            ck = ck ^ lo ^ hi;
            xfer(lo);
            xfer(hi);
        end
        xfer(ck);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("full_nwrites", 32'(wr_addr.size()), 32'd256);
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] !== 8'(i) || wr_data[i] !== {1'(i), 8'(i) ^ 8'h5A}) bad++;
        end
        check("full_contents_bad", 32'(bad), 32'd0);
        check("full_done_cnt", 32'(done_cnt), 32'd1);
        check("full_err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
